// File: rtl/fp_pkg.sv
// fp_pkg: constants and helpers shared by the FPU datapath units.
// Rounding-mode encodings, fflags bit positions and canonical NaN.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Sign 0, exponent all ones, quiet bit set; callers truncate to W.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// fp_mul_round: normalize, round and pack a raw mantissa product.
// Purely combinational; shared with the future FMA unit.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W,
    localparam int PW = 2 * MAN_W + 2
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [PW-1:0]           prod,
    input  logic [2:0]              rm,
    output logic [W-1:0]            result,
    output logic [4:0]              fflags
);

    localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);

    logic [PW-1:0]           wide;
    logic [MAN_W:0]          mant;
    logic [MAN_W+1:0]        mant_r;
    logic                    g, r, s, inc, carry;
    logic                    ovf, unf, max_fin;
    logic signed [EXP_W+1:0] exp_n, exp_f;

    always_comb begin
        // Align so the hidden bit always sits at the product MSB.
        wide  = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
        mant  = wide[PW-1:MAN_W+1];
        g     = wide[MAN_W];
        r     = wide[MAN_W-1];
        s     = |wide[MAN_W-2:0];
        exp_n = exp_in + $signed({{(EXP_W+1){1'b0}}, prod[PW-1]});

        unique case (1'b1)
            rm == RM_RTZ: inc = 1'b0;
            rm == RM_RDN: inc = sign & (g | r | s);
            rm == RM_RUP: inc = !sign & (g | r | s);
            rm == RM_RMM: inc = g;
            default:      inc = g & (r | s | mant[0]);
        endcase

        mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
        carry  = mant_r[MAN_W+1];
        exp_f  = exp_n + $signed({{(EXP_W+1){1'b0}}, carry});

        unf     = exp_f[EXP_W+1] | ~|exp_f;
        ovf     = !exp_f[EXP_W+1] && (exp_f >= EMAX);
        max_fin = (rm == RM_RTZ) | ((rm == RM_RDN) & !sign)
                | ((rm == RM_RUP) & sign);

        fflags          = '0;
        fflags[FLAG_NX] = g | r | s;
        result = {sign, exp_f[EXP_W-1:0],
                  carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0]};

        if (ovf) begin
            fflags[FLAG_OF] = 1'b1;
            fflags[FLAG_NX] = 1'b1;
            result = max_fin
                   ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                   : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            fflags[FLAG_UF] = 1'b1;
            fflags[FLAG_NX] = 1'b1;
            result = {sign, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754 multiplier with valid/ready and tag.
// S1 unpack/specials, S2 mantissa product, S3 round into output regs.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     num_a,
    input  logic [W-1:0]     num_b,
    input  logic [2:0]       r_m,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
    localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MAN_W));

    typedef struct packed {
        logic [TAG_W-1:0]        tag;
        logic [2:0]              rm;
        logic                    sign;
        logic                    spec;
        logic [W-1:0]            spec_res;
        logic                    nv;
        logic signed [EXP_W+1:0] exp;
    } ctl_t;

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf;
    logic             a_nan, b_nan, a_snan, b_snan, inv;

    ctl_t             s0_ctl, s1_ctl, s2_ctl;
    logic             s1_valid, s2_valid, advance;
    logic [MAN_W:0]   s1_ma, s1_mb;
    logic [PW-1:0]    s2_prod;
    logic [W-1:0]     rnd_res;
    logic [4:0]       rnd_flags;

    assign {sa, ea, fa} = num_a;
    assign {sb, eb, fb} = num_b;
    assign sign = sa ^ sb;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subnormals count as zero here, which flushes them without a flag.
    always_comb begin
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
        inv    = (a_zero & b_inf) | (a_inf & b_zero);

        s0_ctl          = '0;
        s0_ctl.tag      = in_tag;
        s0_ctl.rm       = r_m;
        s0_ctl.sign     = sign;
        s0_ctl.nv       = a_snan | b_snan | inv;
        s0_ctl.exp      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        s0_ctl.spec     = 1'b1;

        if (a_nan | b_nan | inv) begin
            s0_ctl.spec_res = QNAN;
        end else if (a_inf | b_inf) begin
            s0_ctl.spec_res = {sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            s0_ctl.spec_res = {sign, {(W-1){1'b0}}};
        end else begin
            s0_ctl.spec = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_ctl  <= s0_ctl;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s2_ctl  <= s1_ctl;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        end
    end

    fp_mul_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign   (s2_ctl.sign),
        .exp_in (s2_ctl.exp),
        .prod   (s2_prod),
        .rm     (s2_ctl.rm),
        .result (rnd_res),
        .fflags (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            fflags    <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_tag <= s2_ctl.tag;
                result  <= s2_ctl.spec ? s2_ctl.spec_res : rnd_res;
                fflags  <= s2_ctl.spec ? {s2_ctl.nv, 4'b0000} : rnd_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed scoreboard bench for the binary32 multiplier.
// Expected products are constants queued at issue, popped at output.
module tb_fp_mul_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] num_a, num_b;
    logic [2:0]  r_m;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag, fflags;

    int n_asserts = 0;
    int n_fail = 0;
    logic bp_en = 1'b0;
    logic or_hold = 1'b1;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic held = 1'b0;
    logic [41:0] held_v;

    logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] bp_r [8] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000,
        32'h40000000, 32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000};

    fp_mul_pipe #(
        .EXP_W(8),
        .MAN_W(23),
        .TAG_W(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_a     (num_a),
        .num_b     (num_b),
        .r_m       (r_m),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .fflags    (fflags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : or_hold;
    end

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_asserts++;
                assert (out_valid && {result, out_tag, fflags} === held_v) else begin
                    n_fail++;
                    $error("FAIL stall_hold: got v=%b %h expected v=1 %h",
                           out_valid, {result, out_tag, fflags}, held_v);
                end
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                n_asserts++;
                assert (sb_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: got tag %0d res %h expected none",
                           out_tag, result);
                end
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    n_asserts++;
                    assert (out_tag === mon_e.tag && result === mon_e.res
                            && fflags === mon_e.fl) else begin
                        n_fail++;
                        $error("FAIL out_tag%0d: got tag %0d res %h fl %b expected tag %0d res %h fl %b",
                               mon_e.tag, out_tag, result, fflags,
                               mon_e.tag, mon_e.res, mon_e.fl);
                    end
                end
            end else begin
                held = out_valid;
                held_v = {result, out_tag, fflags};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_asserts++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, input logic [4:0] t,
                        input logic [31:0] er, input logic [4:0] ef,
                        input bit push);
        int n;
        exp_t e;
        num_a = a;
        num_b = b;
        r_m = m;
        in_tag = t;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_asserts++;
        assert (in_ready) else begin
            n_fail++;
            $error("FAIL in_ready_tag%0d: got %b expected 1", t, in_ready);
        end
        if (push) begin
            e.tag = t;
            e.res = er;
            e.fl = ef;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_latency(input string name);
        int c = 1;
        while (!out_valid && c < 10) begin
            @(posedge clk);
            #2;
            c++;
        end
        n_asserts++;
        assert (c == 3) else begin
            n_fail++;
            $error("FAIL latency_%s: got %0d cycles expected 3", name, c);
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sb_q.size() != 0 && n < lim) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_asserts++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        num_a = '0;
        num_b = '0;
        r_m = RM_RNE;
        in_tag = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_fflags", 32'(fflags), 32'd0);

        send(32'h40000000, 32'h40400000, RM_RNE, 5'd1, 32'h40C00000, 5'h00, 1);
        in_valid = 1'b0;
        check_latency("basic");
        drain(20);

        send(32'h3F800001, 32'h3F800001, RM_RNE, 5'd2, 32'h3F800002, 5'h01, 1);
        send(32'h3F800001, 32'h3F800001, RM_RTZ, 5'd3, 32'h3F800002, 5'h01, 1);
        send(32'h3F800001, 32'h3F800001, RM_RUP, 5'd4, 32'h3F800003, 5'h01, 1);
        send(32'h3F800001, 32'h3F800001, RM_RMM, 5'd5, 32'h3F800002, 5'h01, 1);
        send(32'h3F800001, 32'h3F800001, 3'b111, 5'd6, 32'h3F800002, 5'h01, 1);
        send(32'h7F7FFFFF, 32'h40000000, RM_RNE, 5'd7, 32'h7F800000, 5'h05, 1);
        send(32'h7F7FFFFF, 32'h40000000, RM_RTZ, 5'd8, 32'h7F7FFFFF, 5'h05, 1);
        send(32'hFF7FFFFF, 32'h40000000, RM_RDN, 5'd9, 32'hFF800000, 5'h05, 1);
        send(32'h7F7FFFFF, 32'h40000000, RM_RDN, 5'd10, 32'h7F7FFFFF, 5'h05, 1);
        send(32'h00000000, 32'h7F800000, RM_RNE, 5'd11, 32'h7FC00000, 5'h10, 1);
        send(32'h7F800001, 32'h3F800000, RM_RNE, 5'd12, 32'h7FC00000, 5'h10, 1);
        send(32'h7FC00000, 32'h3F800000, RM_RNE, 5'd13, 32'h7FC00000, 5'h00, 1);
        send(32'h00800000, 32'h00800000, RM_RNE, 5'd14, 32'h00000000, 5'h03, 1);
        send(32'h7F800000, 32'hC0000000, RM_RNE, 5'd15, 32'hFF800000, 5'h00, 1);
        send(32'h80000000, 32'h3F800000, RM_RNE, 5'd16, 32'h80000000, 5'h00, 1);
        send(32'h00000001, 32'h40000000, RM_RNE, 5'd17, 32'h00000000, 5'h00, 1);
        in_valid = 1'b0;
        drain(60);

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(bp_a[i], 32'h3F000000, RM_RNE, 5'(20 + i), bp_r[i], 5'h00, 1);
        end
        in_valid = 1'b0;
        drain(400);
        bp_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end

        or_hold = 1'b0;
        @(posedge clk);
        #2;
        send(32'h40000000, 32'h40000000, RM_RNE, 5'd29, 32'h0, 5'h00, 0);
        send(32'h40400000, 32'h40000000, RM_RNE, 5'd30, 32'h0, 5'h00, 0);
        send(32'h40800000, 32'h40000000, RM_RNE, 5'd31, 32'h0, 5'h00, 0);
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        or_hold = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        repeat (5) begin
            @(posedge clk);
            #2;
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        send(32'h40400000, 32'h40400000, RM_RNE, 5'd7, 32'h41100000, 5'h00, 1);
        in_valid = 1'b0;
        check_latency("post_reset");
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
